// File: rtl/rx_unstriper.sv
// rx_unstriper: reassembles a byte stream into 4-lane frames, lanes 0-2 staged
// and released together with lane 3; counts frames aborted by loss of alignment.
module rx_unstriper #(
  parameter int DATA_W = 8
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              active,
  input  logic [DATA_W-1:0] data_rx000,
  input  logic              valid_rx000,
  output logic [DATA_W-1:0] data_0rx,
  output logic [DATA_W-1:0] data_1rx,
  output logic [DATA_W-1:0] data_2rx,
  output logic [DATA_W-1:0] data_3rx,
  output logic              valid_0rx,
  output logic              valid_1rx,
  output logic              valid_2rx,
  output logic              valid_3rx,
  output logic              frame_valid,
  output logic [7:0]        abort_count
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                     r_state;
  logic [1:0]                 r_ptr;
  logic [2:0][DATA_W-1:0]     r_stg_d;
  logic [2:0]                 r_stg_v;
  logic [DATA_W-1:0]          w_byte;
  // invalid bytes are zeroed at capture so staging already holds the output value
  assign w_byte = valid_rx000 ? data_rx000 : '0;
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_stg_d     <= '0;
      r_stg_v     <= '0;
      data_0rx    <= '0;
      data_1rx    <= '0;
      data_2rx    <= '0;
      data_3rx    <= '0;
      valid_0rx   <= 1'b0;
      valid_1rx   <= 1'b0;
      valid_2rx   <= 1'b0;
      valid_3rx   <= 1'b0;
      frame_valid <= 1'b0;
      abort_count <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (r_state == IDLE) begin
        r_ptr <= '0;
        if (active) r_state <= RUN;
      end else if (active) begin
        r_ptr <= r_ptr + 2'd1;
        if (r_ptr == 2'd3) begin
          data_0rx    <= r_stg_d[0];
          data_1rx    <= r_stg_d[1];
          data_2rx    <= r_stg_d[2];
          data_3rx    <= w_byte;
          valid_0rx   <= r_stg_v[0];
          valid_1rx   <= r_stg_v[1];
          valid_2rx   <= r_stg_v[2];
          valid_3rx   <= valid_rx000;
          frame_valid <= 1'b1;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (r_ptr == 2'(i)) begin
              r_stg_d[i] <= w_byte;
              r_stg_v[i] <= valid_rx000;
            end
          end
        end
      end else begin
        r_state <= IDLE;
        r_ptr   <= '0;
        r_stg_d <= '0;
        r_stg_v <= '0;
        if (r_ptr != 2'd0 && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_rx_unstriper.sv
// tb_rx_unstriper: randomized and directed stimulus against a queue-based frame
// model; a negedge monitor pops expected frames and checks held outputs.
module tb_rx_unstriper;
  localparam int DW = 8;
  localparam int FW = 4 * (DW + 1);
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          active = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] d0, d1, d2, d3;
  logic          v0, v1, v2, v3, frame_valid;
  logic [7:0]    abort_count;
  int            errors = 0;
  int            checks = 0;
  bit            in_run = 1'b0;
  int            m_aborts = 0;
  logic [DW:0]   pend[$];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] last = '0;
  logic [FW-1:0] got, exp_f;

  rx_unstriper #(.DATA_W(DW)) dut (
    .clk_4f(clk), .reset(reset), .active(active),
    .data_rx000(data_in), .valid_rx000(valid_in),
    .data_0rx(d0), .data_1rx(d1), .data_2rx(d2), .data_3rx(d3),
    .valid_0rx(v0), .valid_1rx(v1), .valid_2rx(v2), .valid_3rx(v3),
    .frame_valid(frame_valid), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  assign got = {v3, v2, v1, v0, d3, d2, d1, d0};

  function automatic logic [FW-1:0] make_frame();
    logic [3:0]         vs;
    logic [4*DW-1:0]    ds;
    for (int i = 0; i < 4; i++) begin
      vs[i] = pend[i][DW];
      ds[i*DW +: DW] = pend[i][DW] ? pend[i][DW-1:0] : '0;
    end
    return {vs, ds};
  endfunction

  // model of one sampled edge, using the input values held across that edge
  task automatic model_edge();
    if (!in_run) begin
      if (active) in_run = 1'b1;
    end else if (active) begin
      pend.push_back({valid_in, data_in});
      if (pend.size() == 4) begin
        exp_q.push_back(make_frame());
        pend.delete();
      end
    end else begin
      if (pend.size() != 0) m_aborts = (m_aborts >= 255) ? 255 : m_aborts + 1;
      pend.delete();
      in_run = 1'b0;
    end
  endtask

  task automatic step(input logic a, input logic v, input logic [DW-1:0] d);
    active = a; valid_in = v; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    in_run = 1'b0; m_aborts = 0; pend.delete(); exp_q.delete(); last = '0;
  endtask

  always @(negedge clk) begin
    checks++;
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_extra: got frame %h with no frame expected", got);
      end else begin
        exp_f = exp_q.pop_front();
        last = exp_f;
        if (got !== exp_f) begin
          errors++;
          $display("FAIL frame_data: got %h expected %h", got, exp_f);
        end
      end
    end else if (exp_q.size() != 0) begin
      exp_f = exp_q.pop_front();
      last = exp_f;
      errors++;
      $display("FAIL frame_missing: frame_valid=0 expected frame %h", exp_f);
    end else if (got !== last) begin
      errors++;
      $display("FAIL frame_hold: got %h expected held %h", got, last);
    end
    checks++;
    if (abort_count !== 8'(m_aborts)) begin
      errors++;
      $display("FAIL abort_count: got %0d expected %0d", abort_count, m_aborts);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    // basic frame
    step(1'b1, 1'b1, 8'h11); step(1'b1, 1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33); step(1'b1, 1'b1, 8'h44);
    // streaming
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 8'(i));
    // invalid lane 1
    step(1'b1, 1'b1, 8'hA0); step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b1, 8'hA2); step(1'b1, 1'b1, 8'hA3);
    // abort after two bytes, then restart
    step(1'b1, 1'b1, 8'hE0); step(1'b1, 1'b1, 8'hE1);
    step(1'b0, 1'b1, 8'hE2);
    step(1'b1, 1'b1, 8'hE3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h55 + i));
    // asynchronous reset mid-frame
    step(1'b1, 1'b1, 8'hC0); step(1'b1, 1'b1, 8'hC1); step(1'b1, 1'b1, 8'hC2);
    reset = 1'b0;
    #1;
    checks++;
    if (got !== '0 || frame_valid !== 1'b0 || abort_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: lanes %h fv %b aborts %0d expected all zero", got, frame_valid, abort_count);
    end
    model_reset();
    #1 reset = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h70 + i));
    // saturation: 300 aborts
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 8'(i));
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
    end
    checks++;
    if (abort_count !== 8'd255) begin
      errors++;
      $display("FAIL abort_saturate: got %0d expected 255", abort_count);
    end
    // random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), 8'($urandom));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_unstriper.md
RX_UNSTRIPER -- requirements
Module: rx_unstriper

Interface
REQ-001 Parameter: DATA_W, default 8, lane byte width; all data ports SHALL use DATA_W bits.
REQ-002 clk_4f  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low SHALL force reset state immediately, independent of clk_4f.
REQ-004 active  input  1  alignment-achieved flag from the serial-to-parallel stage.
REQ-005 data_rx000  input  DATA_W  recovered byte stream, one byte per clk_4f cycle.
REQ-006 valid_rx000  input  1  qualifies data_rx000.
REQ-007 data_0rx, data_1rx, data_2rx, data_3rx  output  DATA_W each  reassembled lane bytes, registered.
REQ-008 valid_0rx, valid_1rx, valid_2rx, valid_3rx  output  1 each  per-lane valid, registered.
REQ-009 frame_valid  output  1  one-cycle pulse marking a new complete 4-lane frame on the lane outputs.
REQ-010 abort_count  output  8  saturating count of partial frames discarded.

Function
REQ-011 FSM SHALL have two states: IDLE and RUN.
REQ-012 IDLE: lane pointer ptr = 0, no capture; transition to RUN on the edge where active = 1 is sampled, with no capture on that edge.
REQ-013 RUN: each edge with active = 1 SHALL capture {valid_rx000, data_rx000} into lane ptr and advance ptr by 1 modulo 4.
REQ-014 Byte order: first byte after entering RUN -> lane 0, then lanes 1, 2, 3, repeating.
REQ-015 Lanes 0-2 SHALL be held in internal staging registers; lane outputs SHALL NOT change while lanes 0-2 are captured.
REQ-016 On the edge capturing lane 3, all four lane output pairs SHALL load together: lanes 0-2 from staging, lane 3 directly from the inputs. Latency: lane 3 byte sampled at edge N appears on the outputs after edge N.
REQ-017 frame_valid SHALL be 1 for exactly the one cycle following each lane-3 capture edge and 0 otherwise.
REQ-018 For any lane whose captured valid is 0, the data_Nrx output SHALL be 0 for that frame, and valid_Nrx SHALL be 0.
REQ-019 Lane outputs SHALL hold their last complete frame until the next complete frame loads them; a complete frame is produced every 4 cycles in steady state.
REQ-020 Active drop in RUN: if active = 0 is sampled with ptr != 0, the FSM SHALL return to IDLE, discard staging, set ptr = 0, leave lane outputs unchanged, assert no frame_valid, and increment abort_count.
REQ-021 Active drop in RUN with ptr = 0: the FSM SHALL return to IDLE with no abort_count increment.
REQ-022 abort_count SHALL saturate at 255 and never wrap.
REQ-023 After re-entry to RUN, reassembly SHALL restart at lane 0; no staged byte from before the drop may appear in any output frame.

Reset
REQ-024 While reset = 0: state = IDLE, ptr = 0, staging = 0, all data_Nrx = 0, all valid_Nrx = 0, frame_valid = 0, abort_count = 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame without incrementing abort_count.
REQ-026 After reset deasserts, the block SHALL wait in IDLE for active = 1.

Verification
REQ-027 Basic frame: active = 1, then bytes 0x11, 0x22, 0x33, 0x44 with valid = 1 -> one cycle after the 0x44 edge, data_0rx..3rx = 11/22/33/44, valid_0rx..3rx = 1111, frame_valid pulses for 1 cycle.
REQ-028 Streaming: 12 consecutive valid bytes 0x01..0x0C -> three frame_valid pulses exactly 4 cycles apart; the last frame = 09/0A/0B/0C.
REQ-029 Invalid lane: bytes A0, A1(valid = 0), A2, A3 -> outputs A0/00/A2/A3, valids 1011.
REQ-030 Abort: after 2 bytes, drop active for 1 cycle, then restart with 0x55..0x58 -> abort_count = 1, the previous frame is held until the new frame 55/56/57/58 loads, no stale byte appears.
REQ-031 Reset mid-frame: after 3 bytes, pulse reset low asynchronously between edges -> all outputs = 0 immediately and abort_count = 0; the next 4 bytes form lane 0-3.
REQ-032 Saturation: force 300 aborts -> abort_count holds at 255.
